lcd_nibble_writer: RTL and testbench

- Physical-layer stage directly downstream of the LCD init/text sequencer; drives the HD44780-compatible 4-bit bus (LCD_D, LCD_E).
- Accepts one byte, or one bare nibble, per start pulse, together with an RS flag and a post-write delay.
- Sequences setup, E-high and hold timing, then the command delay, and reports completion.
- Upstream sequencer issues one transfer at a time and waits for done.

---
 rtl/lcd_nibble_writer.sv | 185 ++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus writer: sends a byte (two nibbles) or a single nibble with
// setup / E-high / gap timing, then an optional post-write delay, then pulses done.
`timescale 1ns/1ps

module lcd_nibble_writer #(
  parameter int SETUP_CYC  = 4,
  parameter int E_HIGH_CYC = 12,
  parameter int GAP_CYC    = 50,
  parameter int DELAY_W    = 20
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [7:0]         data,
  input  logic               rs,
  input  logic               nibble_only,
  input  logic [DELAY_W-1:0] delay,
  output logic               busy,
  output logic               done,
  output logic [4:0]         LCD_D,
  output logic               LCD_E
);

  localparam int PH_MAX = (SETUP_CYC > E_HIGH_CYC)
                        ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                        : ((E_HIGH_CYC > GAP_CYC) ? E_HIGH_CYC : GAP_CYC);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, SETUP_H, EHI_H, GAP_H, SETUP_L, EHI_L, GAP_L, WAIT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
  logic [DELAY_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [3:0]          lo_nib_q, lo_nib_d;
  logic                rs_q, rs_d;
  logic                nib_q, nib_d;
  logic [4:0]          lcd_d_q, lcd_d_d;
  logic                lcd_e_q, lcd_e_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ph_last;

  // Terminal count of the timed phase the FSM is currently in.
  function automatic logic [PH_W-1:0] phase_end(input state_t s);
    case (s)
      SETUP_H, SETUP_L: phase_end = PH_W'(SETUP_CYC - 1);
      EHI_H, EHI_L:     phase_end = PH_W'(E_HIGH_CYC - 1);
      default:          phase_end = PH_W'(GAP_CYC - 1);
    endcase
  endfunction

  assign ph_last = (ph_cnt_q == phase_end(state_q));

  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    wait_cnt_d = wait_cnt_q;
    delay_d    = delay_q;
    lo_nib_d   = lo_nib_q;
    rs_d       = rs_q;
    nib_d      = nib_q;
    lcd_d_d    = lcd_d_q;
    lcd_e_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          // High nibble goes straight onto the bus so setup starts this edge.
          state_d  = SETUP_H;
          busy_d   = 1'b1;
          ph_cnt_d = '0;
          delay_d  = delay;
          lo_nib_d = data[3:0];
          rs_d     = rs;
          nib_d    = nibble_only;
          lcd_d_d  = {rs, data[7:4]};
        end
      end

      SETUP_H, SETUP_L: begin
        if (ph_last) begin
          state_d  = (state_q == SETUP_H) ? EHI_H : EHI_L;
          ph_cnt_d = '0;
          lcd_e_d  = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      EHI_H, EHI_L: begin
        lcd_e_d = 1'b1;
        if (ph_last) begin
          state_d  = (state_q == EHI_H) ? GAP_H : GAP_L;
          ph_cnt_d = '0;
          lcd_e_d  = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      GAP_H: begin
        if (ph_last) begin
          ph_cnt_d   = '0;
          wait_cnt_d = '0;
          if (nib_q) begin
            state_d = WAIT;
          end else begin
            state_d = SETUP_L;
            lcd_d_d = {rs_q, lo_nib_q};
          end
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      GAP_L: begin
        if (ph_last) begin
          ph_cnt_d   = '0;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      // Counts 0..delay inclusive: the extra turnaround cycle places done at
      // k+T+1, and stopping at equality means an all-ones delay never wraps.
      WAIT: begin
        if (wait_cnt_q == delay_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + DELAY_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ph_cnt_q   <= '0;
      wait_cnt_q <= '0;
      delay_q    <= '0;
      lo_nib_q   <= '0;
      rs_q       <= 1'b0;
      nib_q      <= 1'b0;
      lcd_d_q    <= '0;
      lcd_e_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      delay_q    <= delay_d;
      lo_nib_q   <= lo_nib_d;
      rs_q       <= rs_d;
      nib_q      <= nib_d;
      lcd_d_q    <= lcd_d_d;
      lcd_e_q    <= lcd_e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign LCD_D = lcd_d_q;
  assign LCD_E = lcd_e_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: directed transfers plus randomized transfers
// checked against a latency/nibble model and a free-running bus monitor.
`timescale 1ns/1ps

module tb_lcd_nibble_writer;

  localparam int SETUP_CYC  = 4;
  localparam int E_HIGH_CYC = 12;
  localparam int GAP_CYC    = 50;
  localparam int DELAY_W    = 20;
  localparam int PER        = SETUP_CYC + E_HIGH_CYC + GAP_CYC;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         data = 8'h00;
  logic               rs = 1'b0;
  logic               nibble_only = 1'b0;
  logic [DELAY_W-1:0] delay = '0;
  logic               busy, done, LCD_E;
  logic [4:0]         LCD_D;

  int errs = 0;
  int checks = 0;

  bit         mon_en = 1'b0;
  logic [4:0] pulse_q[$];
  logic       prev_e = 1'b0;
  logic [4:0] prev_d = 5'h00;
  int         e_run = 0;
  int         low_stable = 0;

  lcd_nibble_writer #(
    .SETUP_CYC(SETUP_CYC), .E_HIGH_CYC(E_HIGH_CYC), .GAP_CYC(GAP_CYC), .DELAY_W(DELAY_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .data(data), .rs(rs),
    .nibble_only(nibble_only), .delay(delay), .busy(busy), .done(done),
    .LCD_D(LCD_D), .LCD_E(LCD_E)
  );

  always #5 CLK = ~CLK;

  // Bus monitor: data stable while E high, exact E width, setup before E rise.
  always @(negedge CLK) begin
    if (!mon_en || !RST_N) begin
      prev_e = 1'b0; prev_d = LCD_D; e_run = 0; low_stable = 0;
    end else begin
      if (prev_e) begin
        checks++;
        if (LCD_D !== prev_d) begin
          errs++;
          $display("FAIL bus_stable: LCD_D moved %h -> %h with E high", prev_d, LCD_D);
        end
      end
      if (LCD_E) begin
        if (!prev_e) begin
          pulse_q.push_back(LCD_D);
          checks++;
          if (low_stable < SETUP_CYC) begin
            errs++;
            $display("FAIL setup_time: got %0d cycles, need >= %0d", low_stable, SETUP_CYC);
          end
        end
        e_run++;
      end else begin
        if (prev_e) begin
          checks++;
          if (e_run != E_HIGH_CYC) begin
            errs++;
            $display("FAIL e_width: got %0d cycles, expected %0d", e_run, E_HIGH_CYC);
          end
        end
        e_run = 0;
        if (LCD_D !== prev_d) low_stable = 1;
        else low_stable++;
      end
      prev_e = LCD_E; prev_d = LCD_D;
    end
  end

  function automatic int exp_lat(input bit n, input int dly);
    return (n ? 1 : 2) * PER + dly + 1;
  endfunction

  // Present a request for one cycle, then scramble the inputs after acceptance.
  task automatic launch(input logic [7:0] d, input logic r, input logic n,
                        input logic [DELAY_W-1:0] dly);
    @(negedge CLK);
    data = d; rs = r; nibble_only = n; delay = dly; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    data = 8'($urandom); rs = 1'($urandom); nibble_only = 1'($urandom);
    delay = DELAY_W'($urandom);
  endtask

  task automatic wait_done(input string name, input int exp, input bit noise, output int got);
    got = -1;
    for (int c = 1; c <= exp + 20; c++) begin
      start = (noise && c < exp) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLK);
      if (done) begin
        got = c;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, got, exp);
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s busy_at_done: got %b, expected 0", name, busy);
    end
  endtask

  task automatic check_pulses(input string name, input logic [7:0] d, input logic r, input logic n);
    logic [4:0] exp_q[$];
    exp_q.push_back({r, d[7:4]});
    if (!n) exp_q.push_back({r, d[3:0]});
    checks++;
    if (pulse_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL %s pulse_count: got %0d, expected %0d", name, pulse_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (pulse_q[i] !== exp_q[i]) begin
          errs++;
          $display("FAIL %s nibble%0d: got %h, expected %h", name, i, pulse_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_after_done(input string name, input logic [4:0] last_d);
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || LCD_E !== 1'b0 || LCD_D !== last_d) begin
      errs++;
      $display("FAIL %s idle_after: done=%b busy=%b E=%b D=%h, expected 0 0 0 %h",
               name, done, busy, LCD_E, LCD_D, last_d);
    end
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (LCD_D !== 5'h00 || LCD_E !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: D=%h E=%b busy=%b done=%b, expected 00 0 0 0",
               LCD_D, LCD_E, busy, done);
    end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (LCD_D !== 5'h00 || LCD_E !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL idle_state: D=%h E=%b busy=%b done=%b, expected 00 0 0 0",
               LCD_D, LCD_E, busy, done);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_byte();
    int got;
    pulse_q.delete();
    launch(8'h41, 1'b1, 1'b0, '0);
    checks++;
    if (LCD_D !== 5'h14 || busy !== 1'b1 || LCD_E !== 1'b0) begin
      errs++;
      $display("FAIL byte_accept: D=%h busy=%b E=%b, expected 14 1 0", LCD_D, busy, LCD_E);
    end
    wait_done("byte", 133, 1'b0, got);
    check_pulses("byte", 8'h41, 1'b1, 1'b0);
    check_after_done("byte", 5'h11);
  endtask

  task automatic test_nibble();
    int got;
    pulse_q.delete();
    launch(8'h30, 1'b0, 1'b1, '0);
    wait_done("nibble", 67, 1'b0, got);
    check_pulses("nibble", 8'h30, 1'b0, 1'b1);
    check_after_done("nibble", 5'h03);
  endtask

  task automatic test_delay();
    int got;
    pulse_q.delete();
    launch(8'h01, 1'b0, 1'b0, DELAY_W'(76000));
    wait_done("delay", 132 + 76000 + 1, 1'b1, got);
    check_pulses("delay", 8'h01, 1'b0, 1'b0);
    check_after_done("delay", 5'h01);
  endtask

  task automatic test_back_to_back();
    int got = -1;
    pulse_q.delete();
    launch(8'h41, 1'b1, 1'b0, '0);
    for (int c = 1; c <= 160; c++) begin
      if (c == 132) begin
        start = 1'b1; data = 8'h42; rs = 1'b1; nibble_only = 1'b0; delay = '0;
      end
      @(negedge CLK);
      if (done) begin
        got = c;
        break;
      end
    end
    checks++;
    if (got != 133 || busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_first: latency %0d busy %b, expected 133 0", got, busy);
    end
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if (LCD_D !== 5'h14 || busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept: D=%h busy=%b done=%b, expected 14 1 0", LCD_D, busy, done);
    end
    check_pulses("b2b_first", 8'h41, 1'b1, 1'b0);
    pulse_q.delete();
    wait_done("b2b_second", 133, 1'b0, got);
    check_pulses("b2b_second", 8'h42, 1'b1, 1'b0);
    check_after_done("b2b_second", 5'h12);
  endtask

  task automatic test_random();
    int got;
    logic [7:0] d;
    logic r, n;
    int dly;
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom); r = 1'($urandom); n = 1'($urandom);
      dly = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
      pulse_q.delete();
      launch(d, r, n, DELAY_W'(dly));
      wait_done("random", exp_lat(n, dly), bit'(i % 2), got);
      check_pulses("random", d, r, n);
      checks++;
      if (LCD_D !== (n ? {r, d[7:4]} : {r, d[3:0]})) begin
        errs++;
        $display("FAIL random_last_d: got %h for data %h rs %b nib %b", LCD_D, d, r, n);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    pulse_q.delete();
    launch(8'h41, 1'b1, 1'b0, '0);
    repeat (SETUP_CYC + 3) @(negedge CLK);
    checks++;
    if (LCD_E !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_ehi: E=%b, expected 1", LCD_E);
    end
    mon_en = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (LCD_E !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_async: E=%b busy=%b, expected 0 0", LCD_E, busy);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (200) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen || LCD_D !== 5'h00 || busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_after: done_seen=%b D=%h busy=%b, expected 0 00 0", seen, LCD_D, busy);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte();
    test_nibble();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_delay();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
